// File: rtl/time_ctrl_pkg.sv
// rtl/time_ctrl_pkg.sv - state encoding, field limits and blink masks for the time-set controller
package time_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_COMMIT   = 2'd3
  } set_state_e;

  localparam logic [6:0] HOUR_MAX  = 7'd23;
  localparam logic [6:0] MIN_MAX   = 7'd59;
  localparam logic [3:0] MASK_HOUR = 4'b1100;
  localparam logic [3:0] MASK_MIN  = 4'b0011;
  localparam logic [3:0] MASK_NONE = 4'b0000;

  // Simultaneous up and down cancel out and leave the value untouched.
  function automatic logic [6:0] wrap_step(input logic [6:0] val, input logic [6:0] max,
                                           input logic up, input logic down);
    logic [6:0] res;
    res = val;
    if (up && !down) begin
      res = (val >= max) ? 7'd0 : val + 7'd1;
    end else if (down && !up) begin
      res = (val == 7'd0) ? max : val - 7'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// rtl/btn_edge_detect.sv - rising-edge pulse from a debounced, already-synchronous button level
module btn_edge_detect (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_level,
  output logic o_rise
);

  logic level_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      level_q <= 1'b0;
    end else begin
      level_q <= i_level;
    end
  end

  assign o_rise = i_level & ~level_q;

endmodule

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - clock time-setting FSM with blink mask; SET_TIMEOUT_EN adds an idle timeout
module time_set_ctrl #(
  parameter int TIMEOUT_TICKS = 20
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btn_mode,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic       i_tick_blink,
  input  logic [6:0] i_cur_hour,
  input  logic [6:0] i_cur_min,
  output logic       o_run_en,
  output logic       o_load,
  output logic [6:0] o_load_hour,
  output logic [6:0] o_load_min,
  output logic [3:0] o_blink_mask,
  output logic [1:0] o_state
);

  import time_ctrl_pkg::*;

  set_state_e state_q, state_d;
  logic [6:0] hour_q, hour_d, min_q, min_d;
  logic       phase_q, phase_d;
  logic       mode_rise, up_rise, down_rise, any_rise, in_set, timeout_hit;

  btn_edge_detect u_mode (.i_clk(i_clk), .i_reset(i_reset), .i_level(i_btn_mode), .o_rise(mode_rise));
  btn_edge_detect u_up   (.i_clk(i_clk), .i_reset(i_reset), .i_level(i_btn_up),   .o_rise(up_rise));
  btn_edge_detect u_down (.i_clk(i_clk), .i_reset(i_reset), .i_level(i_btn_down), .o_rise(down_rise));

  assign any_rise = mode_rise | up_rise | down_rise;
  assign in_set   = (state_q == ST_SET_HOUR) || (state_q == ST_SET_MIN);

`ifdef SET_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_TICKS + 1);
  logic [TO_W-1:0] tick_cnt_q;

  // Any press keeps the user in set mode, so it outranks a coincident final tick.
  assign timeout_hit = in_set && i_tick_blink && !any_rise &&
                       (tick_cnt_q == TO_W'(TIMEOUT_TICKS - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset || any_rise || !in_set || (state_d != state_q)) begin
      tick_cnt_q <= '0;
    end else if (i_tick_blink) begin
      tick_cnt_q <= tick_cnt_q + TO_W'(1);
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_TICKS == 0);
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_RUN;
      hour_q  <= 7'd0;
      min_q   <= 7'd0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    phase_d = phase_q;
    case (state_q)
      ST_RUN: begin
        if (mode_rise) begin
          hour_d  = i_cur_hour;
          min_d   = i_cur_min;
          state_d = ST_SET_HOUR;
        end
      end
      ST_SET_HOUR: begin
        if (mode_rise) state_d = ST_SET_MIN;
        else           hour_d  = wrap_step(hour_q, HOUR_MAX, up_rise, down_rise);
      end
      ST_SET_MIN: begin
        if (mode_rise) state_d = ST_COMMIT;
        else           min_d   = wrap_step(min_q, MIN_MAX, up_rise, down_rise);
      end
      default: state_d = ST_RUN;
    endcase
    if (timeout_hit) state_d = ST_RUN;

    // Restart the blink with the digits visible after entry or any press.
    if (any_rise || ((state_d != state_q) &&
                     ((state_d == ST_SET_HOUR) || (state_d == ST_SET_MIN)))) begin
      phase_d = 1'b0;
    end else if (in_set && i_tick_blink) begin
      phase_d = ~phase_q;
    end
  end

  always_comb begin
    o_blink_mask = MASK_NONE;
    if (phase_q && (state_q == ST_SET_HOUR)) o_blink_mask = MASK_HOUR;
    else if (phase_q && (state_q == ST_SET_MIN)) o_blink_mask = MASK_MIN;
  end

  assign o_state     = state_q;
  assign o_run_en    = (state_q == ST_RUN);
  assign o_load      = (state_q == ST_COMMIT);
  assign o_load_hour = hour_q;
  assign o_load_min  = min_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - self-checking bench for time_set_ctrl against a behavioural model
module tb_time_set_ctrl;

  localparam int TO = 4;
`ifdef SET_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       i_clk = 1'b0;
  logic       i_reset, i_btn_mode, i_btn_up, i_btn_down, i_tick_blink;
  logic [6:0] i_cur_hour, i_cur_min;
  logic       o_run_en, o_load;
  logic [6:0] o_load_hour, o_load_min;
  logic [3:0] o_blink_mask;
  logic [1:0] o_state;

  always #5 i_clk = ~i_clk;

  time_set_ctrl #(.TIMEOUT_TICKS(TO)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_btn_mode(i_btn_mode), .i_btn_up(i_btn_up),
    .i_btn_down(i_btn_down), .i_tick_blink(i_tick_blink), .i_cur_hour(i_cur_hour),
    .i_cur_min(i_cur_min), .o_run_en(o_run_en), .o_load(o_load), .o_load_hour(o_load_hour),
    .o_load_min(o_load_min), .o_blink_mask(o_blink_mask), .o_state(o_state)
  );

  int n_checks = 0;
  int n_fail = 0;
  int load_seen = 0;

  // Model: mode 0=RUN 1=SET_HOUR 2=SET_MIN 3=COMMIT
  int m_mode, m_hour, m_min, m_ticks;
  bit m_phase, p_md, p_up, p_dn;

  logic [21:0] obs;
  assign obs = {o_state, o_run_en, o_load, o_load_hour, o_load_min, o_blink_mask};

  function automatic logic [21:0] exp_vec();
    logic [3:0] mask;
    logic [1:0] st;
    logic [6:0] hh, mm;
    mask = 4'b0000;
    if (m_phase && m_mode == 1) mask = 4'b1100;
    else if (m_phase && m_mode == 2) mask = 4'b0011;
    st = 2'(m_mode);
    hh = 7'(m_hour);
    mm = 7'(m_min);
    return {st, (m_mode == 0), (m_mode == 3), hh, mm, mask};
  endfunction

  task automatic model_step(input bit md, input bit up, input bit dn, input bit tk, input bit rst);
    bit em, eu, ed, any, in_set, enter;
    int nxt, cnt;
    if (rst) begin
      m_mode = 0; m_hour = 0; m_min = 0; m_ticks = 0; m_phase = 0;
      p_md = 0; p_up = 0; p_dn = 0;
      return;
    end
    em = md && !p_md; eu = up && !p_up; ed = dn && !p_dn;
    p_md = md; p_up = up; p_dn = dn;
    any = em || eu || ed;
    nxt = m_mode;
    cnt = m_ticks;
    in_set = (m_mode == 1) || (m_mode == 2);
    case (m_mode)
      0: if (em) begin m_hour = int'(i_cur_hour); m_min = int'(i_cur_min); nxt = 1; end
      1: begin
        if (em) nxt = 2;
        else if (eu && !ed) m_hour = (m_hour + 1) % 24;
        else if (ed && !eu) m_hour = (m_hour + 23) % 24;
      end
      2: begin
        if (em) nxt = 3;
        else if (eu && !ed) m_min = (m_min + 1) % 60;
        else if (ed && !eu) m_min = (m_min + 59) % 60;
      end
      default: nxt = 0;
    endcase
    if (in_set && tk && !any) begin
      cnt = cnt + 1;
      if (TO_EN && cnt == TO) nxt = 0;
    end
    enter = (nxt != m_mode) && (nxt == 1 || nxt == 2);
    if (any || enter) m_phase = 0;
    else if (in_set && tk) m_phase = !m_phase;
    m_ticks = (any || nxt != m_mode || !in_set) ? 0 : cnt;
    m_mode = nxt;
  endtask

  task automatic step(input bit md, input bit up, input bit dn, input bit tk, input bit rst);
    i_btn_mode = md; i_btn_up = up; i_btn_down = dn; i_tick_blink = tk; i_reset = rst;
    @(posedge i_clk);
    model_step(md, up, dn, tk, rst);
    #1;
    if (o_load === 1'b1) load_seen++;
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 1);
    step(1, 1, 1, 1, 1);
    n_checks++;
    if (obs !== {2'd0, 1'b1, 1'b0, 7'd0, 7'd0, 4'd0}) begin
      n_fail++; $display("FAIL reset_values got=%h exp=%h", obs, {2'd0, 1'b1, 1'b0, 7'd0, 7'd0, 4'd0});
    end
    step(0, 0, 0, 0, 0);
    n_checks++;
    if (obs !== exp_vec()) begin n_fail++; $display("FAIL reset_release got=%h exp=%h", obs, exp_vec()); end
  endtask

  task automatic test_enter_set();
    i_cur_hour = 7'd12; i_cur_min = 7'd34;
    step(1, 0, 0, 0, 0);
    n_checks++;
    if ({o_state, o_run_en, o_load_hour, o_load_min} !== {2'd1, 1'b0, 7'd12, 7'd34}) begin
      n_fail++; $display("FAIL enter_set got=%h/%0b/%0d:%0d exp=1/0/12:34", o_state, o_run_en, o_load_hour, o_load_min);
    end
    i_cur_hour = 7'd5; i_cur_min = 7'd6;
    step(1, 0, 0, 0, 0);
    n_checks++;
    if ({o_state, o_load_hour, o_load_min} !== {2'd1, 7'd12, 7'd34}) begin
      n_fail++; $display("FAIL held_mode_single_action got=%0d %0d:%0d exp=1 12:34", o_state, o_load_hour, o_load_min);
    end
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_hour_wrap();
    for (int i = 0; i < 11; i++) begin
      step(0, 1, 0, 0, 0);
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL hour_up_%0d got=%h exp=%h", i, obs, exp_vec()); end
      step(0, 0, 0, 0, 0);
    end
    n_checks++;
    if (o_load_hour !== 7'd23) begin n_fail++; $display("FAIL hour_at_23 got=%0d exp=23", o_load_hour); end
    step(0, 1, 0, 0, 0);
    n_checks++;
    if (o_load_hour !== 7'd0) begin n_fail++; $display("FAIL hour_wrap_up got=%0d exp=0", o_load_hour); end
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    n_checks++;
    if (o_load_hour !== 7'd23) begin n_fail++; $display("FAIL hour_wrap_down got=%0d exp=23", o_load_hour); end
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    n_checks++;
    if ({o_state, o_load_hour} !== {2'd1, 7'd23}) begin
      n_fail++; $display("FAIL hour_up_down_same got=%0d/%0d exp=1/23", o_state, o_load_hour);
    end
    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    n_checks++;
    if ({o_state, o_load_hour, o_load_min} !== {2'd2, 7'd23, 7'd34}) begin
      n_fail++; $display("FAIL mode_with_up got=%0d/%0d:%0d exp=2/23:34", o_state, o_load_hour, o_load_min);
    end
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_min_commit();
    int lb;
    for (int i = 0; i < 25; i++) begin
      step(0, 1, 0, 0, 0);
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL min_up_%0d got=%h exp=%h", i, obs, exp_vec()); end
      step(0, 0, 0, 0, 0);
    end
    n_checks++;
    if (o_load_min !== 7'd59) begin n_fail++; $display("FAIL min_at_59 got=%0d exp=59", o_load_min); end
    step(0, 1, 0, 0, 0);
    n_checks++;
    if (o_load_min !== 7'd0) begin n_fail++; $display("FAIL min_wrap_up got=%0d exp=0", o_load_min); end
    step(0, 0, 0, 0, 0);
    lb = load_seen;
    step(1, 0, 0, 0, 0);
    n_checks++;
    if ({o_state, o_load, o_run_en, o_load_hour, o_load_min} !== {2'd3, 1'b1, 1'b0, 7'd23, 7'd0}) begin
      n_fail++; $display("FAIL commit got=%0d/%0b/%0b %0d:%0d exp=3/1/0 23:00", o_state, o_load, o_run_en, o_load_hour, o_load_min);
    end
    step(1, 1, 0, 0, 0);
    n_checks++;
    if ({o_state, o_load, o_run_en, o_load_hour, o_load_min} !== {2'd0, 1'b0, 1'b1, 7'd23, 7'd0}) begin
      n_fail++; $display("FAIL after_commit got=%0d/%0b/%0b %0d:%0d exp=0/0/1 23:00", o_state, o_load, o_run_en, o_load_hour, o_load_min);
    end
    n_checks++;
    if (load_seen - lb !== 1) begin n_fail++; $display("FAIL load_pulse_count got=%0d exp=1", load_seen - lb); end
  endtask

  task automatic test_blink();
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    n_checks++;
    if ({o_state, o_blink_mask} !== {2'd1, 4'b0000}) begin
      n_fail++; $display("FAIL blink_entry got=%0d/%b exp=1/0000", o_state, o_blink_mask);
    end
    step(0, 0, 0, 1, 0);
    n_checks++;
    if (o_blink_mask !== 4'b1100) begin n_fail++; $display("FAIL blink_tick1 got=%b exp=1100", o_blink_mask); end
    step(0, 0, 0, 1, 0);
    n_checks++;
    if (o_blink_mask !== 4'b0000) begin n_fail++; $display("FAIL blink_tick2 got=%b exp=0000", o_blink_mask); end
    step(0, 0, 0, 1, 0);
    n_checks++;
    if (o_blink_mask !== 4'b1100) begin n_fail++; $display("FAIL blink_tick3 got=%b exp=1100", o_blink_mask); end
    step(0, 1, 0, 0, 0);
    n_checks++;
    if (o_blink_mask !== 4'b0000) begin n_fail++; $display("FAIL blink_press_clear got=%b exp=0000", o_blink_mask); end
    n_checks++;
    if (obs !== exp_vec()) begin n_fail++; $display("FAIL blink_model got=%h exp=%h", obs, exp_vec()); end
  endtask

  task automatic test_timeout();
    int lb;
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    lb = load_seen;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
    end
    if (TO_EN) begin
      n_checks++;
      if ({o_state, o_run_en} !== {2'd0, 1'b1}) begin
        n_fail++; $display("FAIL timeout_exit got=%0d/%0b exp=0/1", o_state, o_run_en);
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
      end
      n_checks++;
      if (o_state !== 2'd2) begin n_fail++; $display("FAIL no_timeout got=%0d exp=2", o_state); end
    end
    n_checks++;
    if (load_seen !== lb) begin n_fail++; $display("FAIL timeout_no_load got=%0d exp=%0d", load_seen, lb); end
    n_checks++;
    if (obs !== exp_vec()) begin n_fail++; $display("FAIL timeout_model got=%h exp=%h", obs, exp_vec()); end
  endtask

  task automatic test_reset_mid_set();
    int lb;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    n_checks++;
    if ({o_state, o_blink_mask} !== {2'd2, 4'b0011}) begin
      n_fail++; $display("FAIL set_min_blink got=%0d/%b exp=2/0011", o_state, o_blink_mask);
    end
    lb = load_seen;
    step(0, 0, 0, 0, 1);
    n_checks++;
    if (obs !== {2'd0, 1'b1, 1'b0, 7'd0, 7'd0, 4'd0}) begin
      n_fail++; $display("FAIL reset_mid_set got=%h exp=%h", obs, {2'd0, 1'b1, 1'b0, 7'd0, 7'd0, 4'd0});
    end
    step(0, 0, 0, 0, 0);
    n_checks++;
    if ({o_state, o_load} !== {2'd0, 1'b0} || load_seen !== lb) begin
      n_fail++; $display("FAIL reset_no_load got=%0d/%0b loads=%0d exp=0/0 loads=%0d", o_state, o_load, load_seen, lb);
    end
  endtask

  task automatic test_random();
    bit md, up, dn, tk, rst;
    for (int i = 0; i < 800; i++) begin
      md = ($urandom_range(0, 3) == 0);
      up = ($urandom_range(0, 2) == 0);
      dn = ($urandom_range(0, 2) == 0);
      tk = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 149) == 0);
      i_cur_hour = 7'($urandom_range(0, 23));
      i_cur_min = 7'($urandom_range(0, 59));
      step(md, up, dn, tk, rst);
      n_checks++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL random_cyc%0d got=%h exp=%h", i, obs, exp_vec()); end
    end
  endtask

  initial begin
    i_reset = 1'b1; i_btn_mode = 1'b0; i_btn_up = 1'b0; i_btn_down = 1'b0;
    i_tick_blink = 1'b0; i_cur_hour = 7'd0; i_cur_min = 7'd0;
    test_reset();
    test_enter_set();
    test_hour_wrap();
    test_min_commit();
    test_blink();
    test_timeout();
    test_reset_mid_set();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_TICKS, default 20, meaning the number of i_tick_blink pulses without a button edge before set mode is abandoned.
REQ-002 SHALL have port i_clk  in  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port i_reset  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port i_btn_mode  in  1  debounced level, synchronous to i_clk; advances the edit field.
REQ-005 SHALL have port i_btn_up  in  1  debounced level; increments the field being edited.
REQ-006 SHALL have port i_btn_down  in  1  debounced level; decrements the field being edited.
REQ-007 SHALL have port i_tick_blink  in  1  one-cycle pulse, about 2 Hz; blink and timeout timebase.
REQ-008 SHALL have port i_cur_hour  in  7  live hour from the time counter, range 0..23.
REQ-009 SHALL have port i_cur_min  in  7  live minute from the time counter, range 0..59.
REQ-010 SHALL have port o_run_en  out  1  enables time-counter advance.
REQ-011 SHALL have port o_load  out  1  one-cycle pulse; counter loads o_load_hour/o_load_min and clears sec/msec.
REQ-012 SHALL have port o_load_hour  out  7  edited hour value.
REQ-013 SHALL have port o_load_min  out  7  edited minute value.
REQ-014 SHALL have port o_blink_mask  out  4  per-FND-digit blank request; bits [3:2] = hour10/hour1, bits [1:0] = min10/min1; 1 = blank.
REQ-015 SHALL have port o_state  out  2  current state code.

Function
REQ-016 SHALL detect a rising edge on each button as level=1 while the registered previous level=0; one press produces exactly one action.
REQ-017 SHALL act on an edge at the same clock edge where the button is first sampled high; outputs reflect the new state after that edge.
REQ-018 SHALL implement states RUN=0, SET_HOUR=1, SET_MIN=2, COMMIT=3.
REQ-019 RUN: a mode edge SHALL copy i_cur_hour/i_cur_min into the edit registers and go to SET_HOUR; up/down edges SHALL be ignored.
REQ-020 SET_HOUR: an up edge SHALL increment hour mod 24 (23->0); a down edge SHALL decrement hour (0->23); a mode edge SHALL go to SET_MIN.
REQ-021 SET_MIN: up/down SHALL wrap minute mod 60 (59->0, 0->59); a mode edge SHALL go to COMMIT.
REQ-022 COMMIT SHALL last exactly one cycle with o_load=1, then go to RUN unconditionally; all button edges in COMMIT SHALL be ignored.
REQ-023 When up and down edges occur in the same cycle, the edit value SHALL NOT change.
REQ-024 When a mode edge coincides with an up/down edge, only the mode transition SHALL occur.
REQ-025 o_run_en SHALL be 1 only in RUN; o_load SHALL be 1 only in COMMIT.
REQ-026 o_load_hour/o_load_min SHALL always present the edit registers.
REQ-027 A blink phase bit SHALL clear on entry to SET_HOUR or SET_MIN and on any button edge, and SHALL toggle on each i_tick_blink while in a SET state.
REQ-028 o_blink_mask SHALL be 4'b1100 in SET_HOUR with phase=1, 4'b0011 in SET_MIN with phase=1, and 4'b0000 otherwise.

Reset
REQ-029 Reset SHALL force state RUN, o_run_en=1, o_load=0, o_blink_mask=0, o_state=0, edit registers=0, phase=0, timeout count=0, and button history=0.
REQ-030 Reset asserted in a SET state SHALL return to RUN without any o_load pulse.

Configuration
REQ-031 With SET_TIMEOUT_EN defined, SHALL count i_tick_blink pulses in SET states, clear the count on any button edge or state entry, and on reaching TIMEOUT_TICKS go to RUN with no load (edits discarded).
REQ-032 Without SET_TIMEOUT_EN, the timeout counter and TIMEOUT_TICKS SHALL have no effect and SET states SHALL persist indefinitely.

Structure
REQ-033 Package time_ctrl_pkg SHALL hold the state encoding, HOUR_MAX=23, MIN_MAX=59, and the mask constants MASK_HOUR/MASK_MIN.
REQ-034 SHALL instantiate sub-module btn_edge_detect (1-bit level in, registered history, edge pulse out) once per button.

Verification
REQ-035 cur=12:34, press mode -> next cycle o_state=1, o_run_en=0, edit=12:34.
REQ-036 In SET_HOUR at 23, press up -> hour=0; press down -> hour=23; up and down in the same cycle -> hour unchanged.
REQ-037 In SET_MIN at 59, press up -> 0; press mode -> exactly one cycle with o_load=1, load=hh:00; then RUN with o_run_en=1.
REQ-038 In SET_HOUR, three i_tick_blink pulses -> mask 1100, 0000, 1100; a button edge -> mask 0000.
REQ-039 With SET_TIMEOUT_EN and TIMEOUT_TICKS=4, four ticks in SET_MIN with no press -> RUN, o_load never asserted.
REQ-040 Reset asserted mid-SET_MIN -> RUN next cycle, all outputs at reset values, no o_load pulse.
